// File: rtl/proc_env_sequencer.sv
// Bring-up controller for the RISC processor: reset/start sequencing, periodic interrupts,
// a host-loaded input queue feeding inputPort, and a capture FIFO logging outputPort changes.
module proc_env_sequencer #(
    parameter int DATA_W     = 16,
    parameter int RST_CYCLES = 2,
    parameter int IRQ_PERIOD = 0,
    parameter int IRQ_WIDTH  = 1,
    parameter int CAP_LOG2   = 3,
    parameter int IN_LOG2    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              stop,
    input  logic [DATA_W-1:0] outputPort,
    input  logic              in_wr_en,
    input  logic [DATA_W-1:0] in_wr_data,
    input  logic              in_advance,
    input  logic              cap_ready,
    output logic              proc_rst,
    output logic              proc_start,
    output logic              proc_interrupt,
    output logic [DATA_W-1:0] inputPort,
    output logic [DATA_W-1:0] cap_data,
    output logic              cap_valid,
    output logic              cap_overflow,
    output logic              in_full,
    output logic              running
);

    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int IRQ_W = (IRQ_PERIOD > 1) ? $clog2(IRQ_PERIOD) : 1;
    localparam int CPW   = CAP_LOG2 + 1;
    localparam int IPW   = IN_LOG2 + 1;

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN} state_t;

    state_t            state, state_nx;
    logic [RC_W-1:0]   rst_cnt, rst_cnt_nx;
    logic [IRQ_W-1:0]  irq_cnt, irq_cnt_nx;
    logic              irq_nx;

    always_comb begin
        state_nx   = state;
        rst_cnt_nx = '0;
        irq_cnt_nx = '0;
        irq_nx     = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && !stop) state_nx = S_RESET;
            end
            S_RESET: begin
                if (stop)
                    state_nx = S_IDLE;
                else if (rst_cnt == RC_W'(RST_CYCLES - 1))
                    state_nx = S_RUN;
                else
                    rst_cnt_nx = rst_cnt + RC_W'(1);
            end
            S_RUN: begin
                if (stop)
                    state_nx = S_IDLE;
                else if (IRQ_PERIOD > 1)
                    irq_cnt_nx = (irq_cnt == IRQ_W'(IRQ_PERIOD - 1)) ? '0 : irq_cnt + IRQ_W'(1);
            end
            default: state_nx = S_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with the state itself.
        if ((IRQ_PERIOD > 0) && (state_nx == S_RUN))
            irq_nx = (int'(irq_cnt_nx) < IRQ_WIDTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            rst_cnt        <= '0;
            irq_cnt        <= '0;
            proc_rst       <= 1'b1;
            proc_start     <= 1'b0;
            proc_interrupt <= 1'b0;
            running        <= 1'b0;
        end else begin
            state          <= state_nx;
            rst_cnt        <= rst_cnt_nx;
            irq_cnt        <= irq_cnt_nx;
            proc_rst       <= (state_nx != S_RUN);
            proc_start     <= (state_nx == S_RUN);
            proc_interrupt <= irq_nx;
            running        <= (state_nx == S_RUN);
        end
    end

    // Capture FIFO
    logic [DATA_W-1:0] cap_mem [2**CAP_LOG2];
    logic [CPW-1:0]    cap_wp, cap_rp, cap_wp_nx, cap_rp_nx;
    logic [DATA_W-1:0] last_val, cap_head_nx;
    logic              cap_change, cap_full_c, cap_pop, cap_push, cap_drop;

    always_comb begin
        cap_change = (state == S_RUN) && (outputPort != last_val);
        cap_full_c = (cap_wp[CAP_LOG2] != cap_rp[CAP_LOG2]) &&
                     (cap_wp[CAP_LOG2-1:0] == cap_rp[CAP_LOG2-1:0]);
        cap_pop    = cap_valid && cap_ready;
        cap_push   = cap_change && (!cap_full_c || cap_pop);
        cap_drop   = cap_change && cap_full_c && !cap_pop;
        cap_wp_nx  = cap_wp + CPW'(cap_push);
        cap_rp_nx  = cap_rp + CPW'(cap_pop);
        // The new head may be the slot written this very cycle; bypass the memory then.
        if (cap_push && (cap_rp_nx[CAP_LOG2-1:0] == cap_wp[CAP_LOG2-1:0]))
            cap_head_nx = outputPort;
        else
            cap_head_nx = cap_mem[cap_rp_nx[CAP_LOG2-1:0]];
    end

    always_ff @(posedge clk) begin
        if (cap_push) cap_mem[cap_wp[CAP_LOG2-1:0]] <= outputPort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_wp       <= '0;
            cap_rp       <= '0;
            cap_valid    <= 1'b0;
            cap_data     <= '0;
            cap_overflow <= 1'b0;
            last_val     <= '0;
        end else begin
            cap_wp       <= cap_wp_nx;
            cap_rp       <= cap_rp_nx;
            cap_valid    <= (cap_wp_nx != cap_rp_nx);
            cap_data     <= cap_head_nx;
            cap_overflow <= cap_overflow | cap_drop;
            if ((state == S_RESET) || cap_change) last_val <= outputPort;
        end
    end

    // Input queue
    logic [DATA_W-1:0] in_mem [2**IN_LOG2];
    logic [IPW-1:0]    in_wp, in_rp, in_wp_nx, in_rp_nx;
    logic [DATA_W-1:0] in_head_nx;
    logic              in_nonempty, in_full_c, in_pop, in_push;

    always_comb begin
        in_nonempty = (in_wp != in_rp);
        in_full_c   = (in_wp[IN_LOG2] != in_rp[IN_LOG2]) &&
                      (in_wp[IN_LOG2-1:0] == in_rp[IN_LOG2-1:0]);
        in_pop      = in_advance && in_nonempty;
        in_push     = in_wr_en && (!in_full_c || in_pop);
        in_wp_nx    = in_wp + IPW'(in_push);
        in_rp_nx    = in_rp + IPW'(in_pop);
        if (in_wp_nx == in_rp_nx)
            in_head_nx = inputPort;
        else if (in_push && (in_rp_nx[IN_LOG2-1:0] == in_wp[IN_LOG2-1:0]))
            in_head_nx = in_wr_data;
        else
            in_head_nx = in_mem[in_rp_nx[IN_LOG2-1:0]];
    end

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wp[IN_LOG2-1:0]] <= in_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_wp     <= '0;
            in_rp     <= '0;
            in_full   <= 1'b0;
            inputPort <= '0;
        end else begin
            in_wp     <= in_wp_nx;
            in_rp     <= in_rp_nx;
            in_full   <= (in_wp_nx[IN_LOG2] != in_rp_nx[IN_LOG2]) &&
                         (in_wp_nx[IN_LOG2-1:0] == in_rp_nx[IN_LOG2-1:0]);
            inputPort <= in_head_nx;
        end
    end

endmodule

// File: tb/tb_proc_env_sequencer.sv
// Scoreboard bench for proc_env_sequencer: queue-based reference model updated on each edge,
// monitor compares every output on the falling edge and pops expected capture entries.
module tb_proc_env_sequencer;
    localparam int DW   = 16;
    localparam int RSTC = 2;
    localparam int IRQP = 5;
    localparam int IRQW = 2;
    localparam int CAPL = 3;
    localparam int INL  = 2;
    localparam int CAPD = 1 << CAPL;
    localparam int IND  = 1 << INL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable, stop, in_wr_en, in_advance, cap_ready;
    logic [DW-1:0] outputPort, in_wr_data;
    logic          proc_rst, proc_start, proc_interrupt, cap_valid, cap_overflow, in_full, running;
    logic [DW-1:0] inputPort, cap_data;

    proc_env_sequencer #(
        .DATA_W(DW), .RST_CYCLES(RSTC), .IRQ_PERIOD(IRQP),
        .IRQ_WIDTH(IRQW), .CAP_LOG2(CAPL), .IN_LOG2(INL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .stop(stop), .outputPort(outputPort),
        .in_wr_en(in_wr_en), .in_wr_data(in_wr_data), .in_advance(in_advance),
        .cap_ready(cap_ready), .proc_rst(proc_rst), .proc_start(proc_start),
        .proc_interrupt(proc_interrupt), .inputPort(inputPort), .cap_data(cap_data),
        .cap_valid(cap_valid), .cap_overflow(cap_overflow), .in_full(in_full),
        .running(running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 bring-up reset, 2 running
    int            mode = 0;
    int            rst_left = 0;
    int            run_cycles = 0;
    logic [DW-1:0] last_m = '0;
    logic [DW-1:0] in_held = '0;
    bit            ovf_m = 1'b0;
    logic [DW-1:0] capq[$];
    logic [DW-1:0] inq[$];

    task automatic model_step();
        bit pop, push;
        if (rst) begin
            mode = 0; rst_left = 0; run_cycles = 0;
            last_m = '0; in_held = '0; ovf_m = 1'b0;
            capq.delete(); inq.delete();
        end else begin
            if (mode == 2 && outputPort != last_m) begin
                if (capq.size() < CAPD) capq.push_back(outputPort);
                else ovf_m = 1'b1;
                last_m = outputPort;
            end else if (mode == 1) begin
                last_m = outputPort;
            end
            pop  = in_advance && (inq.size() > 0);
            push = in_wr_en && ((inq.size() < IND) || pop);
            if (pop) void'(inq.pop_front());
            if (push) inq.push_back(in_wr_data);
            if (inq.size() > 0) in_held = inq[0];
            case (mode)
                0: if (enable && !stop) begin mode = 1; rst_left = RSTC; end
                1: if (stop) mode = 0;
                   else begin
                       rst_left--;
                       if (rst_left == 0) begin mode = 2; run_cycles = 0; end
                   end
                default: if (stop) mode = 0; else run_cycles++;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic monitor_step();
        logic [DW-1:0] exp_d;
        bit irq_e;
        irq_e = (mode == 2) && ((run_cycles % IRQP) < IRQW);
        chk("proc_rst", proc_rst, mode != 2);
        chk("proc_start", proc_start, mode == 2);
        chk("running", running, mode == 2);
        chk("proc_interrupt", proc_interrupt, irq_e);
        chk("cap_valid", cap_valid, capq.size() > 0);
        chk("cap_overflow", cap_overflow, ovf_m);
        chk("in_full", in_full, inq.size() == IND);
        chk("inputPort", inputPort, in_held);
        if (cap_valid && cap_ready) begin
            if (capq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cap_pop_empty: actual=%0h expected=none at %0t", cap_data, $time);
            end else begin
                exp_d = capq.pop_front();
                chk("cap_data", cap_data, exp_d);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        monitor_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] t4v [10] = '{16'h1234, 16'h1234, 16'hBEEF, 16'h0001, 16'h0002,
                                16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
    logic [DW-1:0] pool [4] = '{16'h0000, 16'h00F0, 16'h0F00, 16'hF000};

    initial begin
        enable = 0; stop = 0; outputPort = '0; in_wr_en = 0; in_wr_data = '0;
        in_advance = 0; cap_ready = 0;
        repeat (2) tick();
        rst = 0;

        // bring-up: two reset cycles then run
        enable = 1; tick(); enable = 0;
        tick();
        chk("t1_rst_hold", proc_rst, 1);
        tick();
        chk("t1_rst_release", proc_rst, 0);
        chk("t1_start", proc_start, 1);

        // interrupts over several periods, then stop
        repeat (12) tick();
        stop = 1; tick(); stop = 0;
        chk("t2_irq_clear", proc_interrupt, 0);
        chk("t2_idle", running, 0);
        enable = 1; tick(); enable = 0;
        repeat (2) tick();
        chk("t2_rerun", running, 1);

        // capture ordering and overflow
        for (int i = 0; i < 10; i++) begin
            outputPort = t4v[i];
            tick();
        end
        chk("t4_ovf", cap_overflow, 1);
        chk("t3_head", cap_data, 16'h1234);
        outputPort = 16'h00AA; cap_ready = 1; tick(); cap_ready = 0;
        chk("t4_full_pushpop_valid", cap_valid, 1);
        cap_ready = 1; repeat (12) tick(); cap_ready = 0;
        chk("t4_drained", cap_valid, 0);

        // input queue
        in_wr_en = 1;
        in_wr_data = 16'h000A; tick();
        in_wr_data = 16'h000B; tick();
        in_wr_data = 16'h000C; tick();
        in_wr_en = 0;
        chk("t5_first", inputPort, 16'h000A);
        for (int i = 0; i < 3; i++) begin
            in_advance = 1; tick(); in_advance = 0; tick();
        end
        chk("t5_hold", inputPort, 16'h000C);
        in_wr_en = 1;
        for (int i = 0; i < 5; i++) begin
            in_wr_data = DW'(16'h0010 + i);
            tick();
        end
        in_wr_en = 0;
        chk("t5_full", in_full, 1);
        chk("t5_head", inputPort, 16'h0010);
        in_advance = 1; repeat (4) tick(); in_advance = 0;
        chk("t5_last", inputPort, 16'h0013);
        chk("t5_not_full", in_full, 0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            enable     = ($urandom_range(0, 9) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0) outputPort = pool[$urandom_range(0, 3)];
            in_wr_en   = $urandom_range(0, 1) == 1;
            in_wr_data = DW'($urandom);
            in_advance = ($urandom_range(0, 4) < 2);
            cap_ready  = $urandom_range(0, 1) == 1;
            tick();
        end

        // async reset in the middle of a run with data queued
        enable = 1; stop = 0; in_wr_en = 0; in_advance = 0; cap_ready = 0;
        tick(); enable = 0;
        repeat (3) tick();
        outputPort = 16'h5555; in_wr_en = 1; in_wr_data = 16'h0077; tick();
        outputPort = 16'h6666; in_wr_en = 0; tick();
        chk("t6_pre_valid", cap_valid, 1);
        chk("t6_pre_run", running, 1);
        #2 rst = 1;
        #1;
        chk("t6_proc_rst", proc_rst, 1);
        chk("t6_start", proc_start, 0);
        chk("t6_irq", proc_interrupt, 0);
        chk("t6_running", running, 0);
        chk("t6_cap_valid", cap_valid, 0);
        chk("t6_ovf", cap_overflow, 0);
        chk("t6_in_full", in_full, 0);
        chk("t6_inputPort", inputPort, 0);
        repeat (2) tick();
        rst = 0;
        repeat (3) tick();

        stop = 1; cap_ready = 1; enable = 0;
        repeat (20) tick();
        chk("final_empty", cap_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
